// File: rtl/alu_nibble_sequencer.sv
// Drives a W-bit operation through an external 4-bit ALU one nibble per cycle, LSB first.
// Result is presented NIBBLES cycles after accept and held until out_ready; in_ready only while idle.
package alu_nibble_sequencer_pkg;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_XOR, ALU_XNOR, ALU_AND, ALU_OR, ALU_COMP, ALU_RSHFT
  } alu_cmd_t;
endpackage

module alu_nibble_sequencer
  import alu_nibble_sequencer_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  alu_cmd_t               in_op,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_res,
  output logic                   out_carry,
  output logic                   out_zero,
  output logic [3:0]             alu_d1,
  output logic [3:0]             alu_d2,
  output alu_cmd_t               alu_cmd,
  output logic                   alu_carry_in,
  output logic                   alu_b_inv,
  output logic                   alu_carry_disable,
  input  logic [3:0]             alu_res,
  input  logic                   alu_carry_out
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_idx;
  alu_cmd_t         r_op;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_out_res;
  logic             r_carry;
  logic             r_out_carry;
  logic             r_out_zero;

  logic             w_first;
  logic             w_last;
  logic [W-1:0]     w_b_shr;
  logic [W-1:0]     w_acc_next;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic             w_shr_in;
  logic             w_final_carry;

  assign w_first = (r_idx == '0);
  assign w_last  = (r_idx == IDX_W'(NIBBLES - 1));
  // Bit 3 of each nibble of B>>1 is the bit shifted in from the nibble above (0 at the top).
  assign w_b_shr = r_b >> 1;

  always_comb begin
    w_a_nib    = '0;
    w_b_nib    = '0;
    w_shr_in   = 1'b0;
    w_acc_next = r_acc;
    for (int n = 0; n < NIBBLES; n++) begin
      if (r_idx == IDX_W'(n)) begin
        w_a_nib              = r_a[4*n +: 4];
        w_b_nib              = r_b[4*n +: 4];
        w_shr_in             = w_b_shr[4*n + 3];
        w_acc_next[4*n +: 4] = alu_res;
      end
    end
  end

  always_comb begin
    case (r_op)
      ALU_ADD, ALU_SUB, ALU_COMP: w_final_carry = alu_carry_out;
      ALU_RSHFT:                  w_final_carry = r_b[0];
      default:                    w_final_carry = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    in_ready          = 1'b0;
    out_valid         = 1'b0;
    alu_d1            = '0;
    alu_d2            = '0;
    alu_cmd           = ALU_ADD;
    alu_carry_in      = 1'b0;
    alu_b_inv         = 1'b0;
    alu_carry_disable = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        alu_d1 = w_a_nib;
        alu_d2 = w_b_nib;
        case (r_op)
          ALU_ADD: begin
            alu_carry_in = w_first ? 1'b0 : r_carry;
          end
          ALU_SUB, ALU_COMP: begin
            alu_b_inv    = 1'b1;
            alu_carry_in = w_first ? 1'b1 : r_carry;
          end
          ALU_RSHFT: begin
            alu_cmd      = ALU_RSHFT;
            alu_carry_in = w_shr_in;
          end
          default: begin
            alu_cmd           = r_op;
            alu_carry_disable = 1'b1;
          end
        endcase
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Work accumulates in r_acc; the output registers only load on the final nibble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_op        <= ALU_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_out_res   <= '0;
      r_out_carry <= 1'b0;
      r_out_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op    <= in_op;
            r_a     <= in_a;
            r_b     <= in_b;
            r_idx   <= '0;
            r_carry <= 1'b0;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= alu_carry_out;
          if (w_last) begin
            r_idx       <= '0;
            r_out_res   <= w_acc_next;
            r_out_zero  <= (w_acc_next == '0);
            r_out_carry <= w_final_carry;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_res   = r_out_res;
  assign out_carry = r_out_carry;
  assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: behavioural 4-bit ALU, vector table plus scoreboard queue,
// and hand-written sequences for backpressure, busy-time requests and mid-operation reset.
module tb_alu_nibble_sequencer;
  import alu_nibble_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  alu_cmd_t    in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic        out_carry;
  logic        out_zero;
  logic [3:0]  alu_d1;
  logic [3:0]  alu_d2;
  alu_cmd_t    alu_cmd;
  logic        alu_carry_in;
  logic        alu_b_inv;
  logic        alu_carry_disable;
  logic [3:0]  alu_res;
  logic        alu_carry_out;

  alu_nibble_sequencer #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_carry(out_carry), .out_zero(out_zero),
    .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_cmd(alu_cmd), .alu_carry_in(alu_carry_in),
    .alu_b_inv(alu_b_inv), .alu_carry_disable(alu_carry_disable),
    .alu_res(alu_res), .alu_carry_out(alu_carry_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural 4-bit ALU the sequencer drives.
  logic [3:0] m_bb;
  logic [4:0] m_sum;
  always_comb begin
    m_bb          = alu_b_inv ? ~alu_d2 : alu_d2;
    m_sum         = {1'b0, alu_d1} + {1'b0, m_bb} + {4'b0, alu_carry_in};
    alu_res       = 4'h0;
    alu_carry_out = 1'b0;
    case (alu_cmd)
      ALU_ADD: begin
        alu_res       = m_sum[3:0];
        alu_carry_out = alu_carry_disable ? 1'b0 : m_sum[4];
      end
      ALU_XOR:   alu_res = alu_d1 ^ m_bb;
      ALU_XNOR:  alu_res = ~(alu_d1 ^ m_bb);
      ALU_AND:   alu_res = alu_d1 & m_bb;
      ALU_OR:    alu_res = alu_d1 | m_bb;
      ALU_RSHFT: begin
        alu_res       = {alu_carry_in, alu_d2[3:1]};
        alu_carry_out = alu_d2[0];
      end
      default: begin
        alu_res       = 4'h0;
        alu_carry_out = 1'b0;
      end
    endcase
  end

  typedef struct {
    alu_cmd_t    op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        c;
    logic        z;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        z;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic is_logic_op(input alu_cmd_t op);
    return (op == ALU_XOR) || (op == ALU_XNOR) || (op == ALU_AND) || (op == ALU_OR);
  endfunction

  // One request: accept, count edges to out_valid, compare via scoreboard, stall, release.
  task automatic do_op(input alu_cmd_t op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] res, input logic c, input logic z, input int hold);
    int   lat;
    bit   done;
    exp_t e;
    exp_t got;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    e.res = res; e.c = c; e.z = z;
    sb.push_back(e);
    @(posedge clk);
    lat  = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_op    = alu_cmd_t'($urandom_range(0, 7));
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      if (out_valid) begin
        done = 1'b1;
      end else if (lat >= 20) begin
        check("latency_timeout", 1, 0);
        done = 1'b1;
      end else begin
        check("in_ready_busy", in_ready, 0);
        if (is_logic_op(op)) check("carry_disable_run", alu_carry_disable, 1);
        @(posedge clk);
        lat++;
      end
    end
    check("latency", lat, 4);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      got = sb.pop_front();
      check("out_res", out_res, got.res);
      check("out_carry", out_carry, got.c);
      check("out_zero", out_zero, got.z);
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold_valid", out_valid, 1);
        check("hold_res", out_res, got.res);
        check("hold_flags", {out_carry, out_zero}, {got.c, got.z});
        check("hold_in_ready", in_ready, 0);
      end
    end
    // Release with in_valid high: the request must not be taken on the release edge.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{ALU_ADD,   16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vecs[1]  = '{ALU_SUB,   16'h1234, 16'h1235, 16'hFFFF, 1'b0, 1'b0};
    vecs[2]  = '{ALU_COMP,  16'h5A5A, 16'h5A5A, 16'h0000, 1'b1, 1'b1};
    vecs[3]  = '{ALU_RSHFT, 16'h1234, 16'h8001, 16'h4000, 1'b1, 1'b0};
    vecs[4]  = '{ALU_RSHFT, 16'hFFFF, 16'h0010, 16'h0008, 1'b0, 1'b0};
    vecs[5]  = '{ALU_XNOR,  16'h0F0F, 16'h00FF, 16'hF00F, 1'b0, 1'b0};
    vecs[6]  = '{ALU_ADD,   16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[7]  = '{ALU_AND,   16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
    vecs[8]  = '{ALU_OR,    16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0};
    vecs[9]  = '{ALU_XOR,   16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{ALU_SUB,   16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0};
    vecs[11] = '{ALU_COMP,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0};
    vecs[12] = '{ALU_ADD,   16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = ALU_ADD;
    in_a      = 16'h0;
    in_b      = 16'h0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res", out_res, 0);
    check("rst_flags", {out_carry, out_zero}, 0);
    check("rst_alu_cmd", 32'(alu_cmd), 32'(ALU_ADD));
    check("rst_alu_ops", {alu_d1, alu_d2, alu_carry_in, alu_b_inv, alu_carry_disable}, 0);

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].c, vecs[i].z, (i == 3) ? 2 : 0);
    end

    // Long stall in DONE with requests arriving.
    do_op(ALU_SUB, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0, 10);

    // Reset while RUN is on nibble 2.
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = ALU_ADD;
    in_a     = 16'hFFFF;
    in_b     = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid_run_d1", alu_d1, 4'hF);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_res", out_res, 0);
    check("abort_flags", {out_carry, out_zero}, 0);
    check("abort_alu_ops", {alu_d1, alu_d2, alu_carry_in, alu_b_inv, alu_carry_disable}, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_result", out_valid, 0);
    end
    do_op(ALU_ADD, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_nibble_sequencer.md
ALU_NIBBLE_SEQUENCER -- requirements
Module: alu_nibble_sequencer

Interface
REQ-001 Parameter NIBBLES, default 4; operand width is W = 4*NIBBLES bits, and NIBBLES SHALL be at least 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 in_op  input  AluCmd  operation (ADD, SUB, XOR, XNOR, AND, OR, COMP, RSHFT).
REQ-007 in_a, in_b  input  W  operands A and B.
REQ-008 out_valid  output  1  result held and valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 out_res  output  W  result word.
REQ-011 out_carry, out_zero  output  1 each  final carry flag and (out_res==0) flag.
REQ-012 alu_d1, alu_d2  output  4 each  nibble operands driven to the 4-bit ALU.
REQ-013 alu_cmd, alu_carry_in, alu_b_inv, alu_carry_disable  output  AluCmd/1/1/1  ALU control fields.
REQ-014 alu_res, alu_carry_out  input  4/1  combinational ALU result and carry, sampled in the same cycle as driven.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE & in_valid -> capture in_op, in_a and in_b into registers; clear idx to 0 and the carry register to 0; go to RUN.
REQ-017 RUN SHALL process one nibble per cycle, least-significant first: alu_d1=A[4*idx+:4], alu_d2=B[4*idx+:4]; at the edge, alu_res goes into res[4*idx+:4] and idx increments.
REQ-018 RUN & idx==NIBBLES-1 -> DONE at that edge; out_valid SHALL rise exactly NIBBLES edges after the accept edge.
REQ-019 DONE & out_ready -> IDLE; DONE & !out_ready -> hold out_res and the flags unchanged, indefinitely.
REQ-020 ADD: alu_cmd=ADD, b_inv=0, carry_disable=0; carry_in=0 for nibble 0, then the registered alu_carry_out of the previous nibble.
REQ-021 SUB and COMP: alu_cmd=ADD, b_inv=1, carry_disable=0; carry_in=1 for nibble 0, then chained; out_carry = final carry (1 means A>=B unsigned).
REQ-022 COMP: out_res SHALL equal A-B (mod 2^W); the consumer uses out_carry and out_zero.
REQ-023 XOR, XNOR, AND, OR: alu_cmd=op, b_inv=0, carry_disable=1, carry_in=0; out_carry=0.
REQ-024 RSHFT shifts B right by 1 with zero fill: alu_cmd=RSHFT, carry_in = B[4*idx+4] for idx<NIBBLES-1 and 0 for the top nibble; out_carry = B[0].
REQ-025 ADD/SUB/COMP: out_carry = alu_carry_out of nibble NIBBLES-1; out_zero SHALL be computed from the final full out_res.
REQ-026 Outside RUN, the ALU outputs SHALL be driven to 0 with alu_cmd=ADD.
REQ-027 idx SHALL never exceed NIBBLES-1; no wrap-around occurs within an operation.
REQ-028 in_valid while busy (RUN or DONE) SHALL be ignored; in_* changes after acceptance SHALL not affect the result.
REQ-029 DONE & out_ready & in_valid in the same cycle -> go to IDLE only; the new request is accepted on a later cycle.

Reset
REQ-030 rst_n=0 at an edge -> state IDLE, idx=0, carry register=0, out_res=0, out_carry=0, out_zero=0, out_valid=0, in_ready=1 after that edge.
REQ-031 Reset in RUN or DONE SHALL abort the operation; no partial result is ever presented.

Verification
REQ-032 ADD A=0xFFFF, B=0x0001 -> out_valid 4 edges after accept; out_res=0x0000, out_carry=1, out_zero=1.
REQ-033 SUB A=0x1234, B=0x1235 -> out_res=0xFFFF, out_carry=0, out_zero=0; COMP A=0x5A5A, B=0x5A5A -> out_res=0, out_carry=1, out_zero=1.
REQ-034 RSHFT B=0x8001 -> out_res=0x4000, out_carry=1; RSHFT B=0x0010 -> out_res=0x0008, out_carry=0.
REQ-035 XNOR A=0x0F0F, B=0x00FF -> out_res=0xF00F, out_carry=0; the bench checks alu_carry_disable=1 in all 4 RUN cycles.
REQ-036 out_ready held low 10 cycles in DONE -> out_res stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE the next edge.
REQ-037 rst_n=0 at RUN idx=2 -> next cycle IDLE, all outputs 0, in_ready=1; next ADD 0x0001+0x0002 -> out_res=0x0003.
